// File: rtl/frame_buffer_manager.sv
// N-buffer frame store manager: camera capture writes one buffer while the VGA side
// reads another, switching to the newest committed frame only at display frame start.
module frame_buffer_manager #(
  parameter int NUM_BUFFERS = 2,
  parameter int FRAME_W     = 320,
  parameter int FRAME_H     = 240,
  parameter int PIXEL_W     = 16,
  parameter int ADDR_W      = 17,
  parameter int RD_LAT      = 1,
  localparam int BUF_W      = (NUM_BUFFERS > 2) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic                           clock_50mhz,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           cam_frame_start,
  input  logic                           cam_pixel_valid,
  input  logic [PIXEL_W-1:0]             cam_pixel_data,
  input  logic                           disp_frame_start,
  input  logic [10:0]                    disp_x,
  input  logic [10:0]                    disp_y,
  input  logic [NUM_BUFFERS*PIXEL_W-1:0] mem_rd_data,
  output logic [NUM_BUFFERS-1:0]         mem_wr_en,
  output logic [ADDR_W-1:0]              mem_wr_addr,
  output logic [PIXEL_W-1:0]             mem_wr_data,
  output logic [ADDR_W-1:0]              mem_rd_addr,
  output logic [PIXEL_W-1:0]             pix_out,
  output logic                           pix_active,
  output logic [BUF_W-1:0]               disp_buf,
  output logic [15:0]                    frames_done,
  output logic [15:0]                    frames_dropped,
  output logic                           short_frame_err
);

  localparam int FRAME_PIX = FRAME_W * FRAME_H;
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);
  localparam logic [10:0]      FW_L     = 11'(FRAME_W);
  localparam logic [10:0]      FH_L     = 11'(FRAME_H);

  typedef enum logic [2:0] {
    IDLE, WAIT_SOF, CAPTURE, COMMIT, SELECT, WAIT_SWAP
  } wr_state_t;

  wr_state_t        state;
  logic [BUF_W-1:0] wr_buf;
  logic [BUF_W-1:0] latest;
  logic             have_frame;
  logic [CNT_W-1:0] wr_cnt;
  logic [BUF_W:0]   free_sel;

  // Lowest buffer index that is neither displayed nor holding the latest frame; MSB = found.
  function automatic logic [BUF_W:0] pick_free(input logic [BUF_W-1:0] busy_a,
                                               input logic [BUF_W-1:0] busy_b);
    logic [BUF_W:0] r;
    r = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (BUF_W'(i) != busy_a && BUF_W'(i) != busy_b) r = {1'b1, BUF_W'(i)};
    end
    return r;
  endfunction

  assign free_sel = pick_free(disp_buf, latest);

  always_ff @(posedge clock_50mhz) begin
    if (reset) begin
      state           <= IDLE;
      wr_buf          <= BUF_W'(1);
      latest          <= '0;
      have_frame      <= 1'b0;
      wr_cnt          <= '0;
      mem_wr_en       <= '0;
      mem_wr_addr     <= '0;
      mem_wr_data     <= '0;
      frames_done     <= '0;
      frames_dropped  <= '0;
      short_frame_err <= 1'b0;
    end else begin
      mem_wr_en <= '0;
      case (state)
        IDLE: if (enable) state <= WAIT_SOF;
        WAIT_SOF: begin
          if (cam_frame_start) begin
            wr_cnt <= '0;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (cam_frame_start) begin
            short_frame_err <= 1'b1;
            wr_cnt          <= '0;
          end else if (cam_pixel_valid) begin
            // Never strobe the buffer on screen, whatever the sequencing above.
            if (wr_buf != disp_buf) mem_wr_en <= NUM_BUFFERS'(1) << wr_buf;
            mem_wr_addr <= ADDR_W'(wr_cnt);
            mem_wr_data <= cam_pixel_data;
            wr_cnt      <= wr_cnt + CNT_W'(1);
            if (wr_cnt == LAST_PIX) state <= COMMIT;
          end
        end
        COMMIT: begin
          latest      <= wr_buf;
          have_frame  <= 1'b1;
          frames_done <= frames_done + 16'd1;
          state       <= SELECT;
        end
        SELECT: begin
          if (free_sel[BUF_W]) begin
            wr_buf <= free_sel[BUF_W-1:0];
            state  <= enable ? WAIT_SOF : IDLE;
          end else begin
            state <= WAIT_SWAP;
          end
        end
        WAIT_SWAP: begin
          if (cam_frame_start) frames_dropped <= frames_dropped + 16'd1;
          if (disp_buf == latest) begin
            wr_buf <= free_sel[BUF_W-1:0];
            state  <= WAIT_SOF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Swap uses the registered latest, so a same-edge commit shows one display frame later.
  always_ff @(posedge clock_50mhz) begin
    if (reset) disp_buf <= '0;
    else if (disp_frame_start && have_frame) disp_buf <= latest;
  end

  logic              in_win_p0;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic              vld_pn [RD_LAT+1];
  logic [BUF_W-1:0]  buf_pn [RD_LAT+1];

  assign in_win_p0  = have_frame && (disp_x < FW_L) && (disp_y < FH_L);
  assign rd_addr_p0 = ADDR_W'(disp_y) * ADDR_W'(FRAME_W) + ADDR_W'(disp_x);

  // p0 -> p1: address register; p1 .. p(1+RD_LAT): memory latency; then output register.
  always_ff @(posedge clock_50mhz) begin
    if (reset) begin
      mem_rd_addr <= '0;
      pix_out     <= '0;
      pix_active  <= 1'b0;
      for (int k = 0; k <= RD_LAT; k++) begin
        vld_pn[k] <= 1'b0;
        buf_pn[k] <= '0;
      end
    end else begin
      if (in_win_p0) mem_rd_addr <= rd_addr_p0;
      vld_pn[0] <= in_win_p0;
      buf_pn[0] <= disp_buf;
      for (int k = 1; k <= RD_LAT; k++) begin
        vld_pn[k] <= vld_pn[k-1];
        buf_pn[k] <= buf_pn[k-1];
      end
      pix_active <= vld_pn[RD_LAT];
      pix_out    <= vld_pn[RD_LAT] ? mem_rd_data[buf_pn[RD_LAT]*PIXEL_W +: PIXEL_W] : '0;
    end
  end

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Directed bench for frame_buffer_manager: a 4x2 double-buffer instance with a
// 1-cycle memory model, plus a 4x2 triple-buffer instance for write rotation.
module tb_frame_buffer_manager;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset;

  logic        a_en, a_sof, a_valid, a_dfs;
  logic [15:0] a_data;
  logic [10:0] a_x, a_y;
  logic [31:0] a_rd_data;
  logic [1:0]  a_wr_en;
  logic [16:0] a_wr_addr, a_rd_addr;
  logic [15:0] a_wr_data, a_pix;
  logic        a_act, a_short;
  logic [0:0]  a_disp_buf;
  logic [15:0] a_done, a_drop;

  logic        b_en, b_sof, b_valid, b_dfs;
  logic [15:0] b_data;
  logic [10:0] b_x, b_y;
  logic [47:0] b_rd_data;
  logic [2:0]  b_wr_en;
  logic [16:0] b_wr_addr, b_rd_addr;
  logic [15:0] b_wr_data, b_pix;
  logic        b_act, b_short;
  logic [1:0]  b_disp_buf;
  logic [15:0] b_done, b_drop;

  frame_buffer_manager #(.NUM_BUFFERS(2), .FRAME_W(4), .FRAME_H(2), .PIXEL_W(16),
                         .ADDR_W(17), .RD_LAT(1)) dut_a (
    .clock_50mhz(clk), .reset(reset), .enable(a_en), .cam_frame_start(a_sof),
    .cam_pixel_valid(a_valid), .cam_pixel_data(a_data), .disp_frame_start(a_dfs),
    .disp_x(a_x), .disp_y(a_y), .mem_rd_data(a_rd_data), .mem_wr_en(a_wr_en),
    .mem_wr_addr(a_wr_addr), .mem_wr_data(a_wr_data), .mem_rd_addr(a_rd_addr),
    .pix_out(a_pix), .pix_active(a_act), .disp_buf(a_disp_buf), .frames_done(a_done),
    .frames_dropped(a_drop), .short_frame_err(a_short));

  frame_buffer_manager #(.NUM_BUFFERS(3), .FRAME_W(4), .FRAME_H(2), .PIXEL_W(16),
                         .ADDR_W(17), .RD_LAT(1)) dut_b (
    .clock_50mhz(clk), .reset(reset), .enable(b_en), .cam_frame_start(b_sof),
    .cam_pixel_valid(b_valid), .cam_pixel_data(b_data), .disp_frame_start(b_dfs),
    .disp_x(b_x), .disp_y(b_y), .mem_rd_data(b_rd_data), .mem_wr_en(b_wr_en),
    .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data), .mem_rd_addr(b_rd_addr),
    .pix_out(b_pix), .pix_active(b_act), .disp_buf(b_disp_buf), .frames_done(b_done),
    .frames_dropped(b_drop), .short_frame_err(b_short));

  // Two 8-word buffers with a registered (1-cycle) read port.
  logic [15:0] mem_a [2][8];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++)
      if (a_wr_en[b]) mem_a[b][a_wr_addr[2:0]] <= a_wr_data;
    a_rd_data <= {mem_a[1][a_rd_addr[2:0]], mem_a[0][a_rd_addr[2:0]]};
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof(input bit on_b);
    if (on_b) b_sof = 1'b1; else a_sof = 1'b1;
    tick();
    b_sof = 1'b0;
    a_sof = 1'b0;
  endtask

  // One valid pixel; the write it causes is visible one cycle later.
  task automatic px(input bit on_b, input logic [15:0] d, input logic [3:0] exp_en,
                    input int exp_addr, input string tag);
    if (on_b) begin b_valid = 1'b1; b_data = d; end
    else      begin a_valid = 1'b1; a_data = d; end
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check({tag, "_en"}, on_b ? {29'b0, b_wr_en} : {30'b0, a_wr_en}, 32'(exp_en));
    if (exp_en != 4'b0) begin
      check({tag, "_addr"}, on_b ? {15'b0, b_wr_addr} : {15'b0, a_wr_addr}, 32'(exp_addr));
      check({tag, "_data"}, on_b ? {16'b0, b_wr_data} : {16'b0, a_wr_data}, {16'b0, d});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a_en = 0; a_sof = 0; a_valid = 0; a_dfs = 0; a_data = '0; a_x = '0; a_y = '0;
    b_en = 0; b_sof = 0; b_valid = 0; b_dfs = 0; b_data = '0; b_x = '0; b_y = '0;
    b_rd_data = '0;
    tick();
    tick();
    check("rst_wr_en",  32'(a_wr_en), 32'd0);
    check("rst_done",   32'(a_done), 32'd0);
    check("rst_drop",   32'(a_drop), 32'd0);
    check("rst_short",  32'(a_short), 32'd0);
    check("rst_disp",   32'(a_disp_buf), 32'd0);
    check("rst_act",    32'(a_act), 32'd0);
    check("rst_pix",    32'(a_pix), 32'd0);
    check("rst_rdaddr", 32'(a_rd_addr), 32'd0);
    check("rst_b_en",   32'(b_wr_en), 32'd0);

    // T1: full frame into buffer 1
    reset = 1'b0;
    a_en = 1'b1;
    tick();
    sof(0);
    for (int k = 1; k <= 8; k++) px(0, 16'(k), 4'b0010, k - 1, "t1_px");
    px(0, 16'h0099, 4'b0000, 0, "t1_ignored");
    check("t1_done", 32'(a_done), 32'd1);
    tick();

    // T2: display swap and read pipeline
    a_dfs = 1'b1;
    tick();
    a_dfs = 1'b0;
    check("t2_disp", 32'(a_disp_buf), 32'd1);
    a_x = 11'd2; a_y = 11'd1;
    tick();
    check("t2_rdaddr", 32'(a_rd_addr), 32'd6);
    tick();
    tick();
    check("t2_pix", 32'(a_pix), 32'h0007);
    check("t2_act", 32'(a_act), 32'd1);
    a_x = 11'd5;
    tick();
    check("t2_hold_addr", 32'(a_rd_addr), 32'd6);
    tick();
    tick();
    check("t2_out_act", 32'(a_act), 32'd0);
    check("t2_out_pix", 32'(a_pix), 32'd0);

    // T3: second frame into buffer 0, then two dropped frames
    sof(0);
    for (int k = 1; k <= 8; k++) px(0, 16'(16'h10 + k), 4'b0001, k - 1, "t3_px");
    tick();
    tick();
    check("t3_done", 32'(a_done), 32'd2);
    sof(0);
    px(0, 16'h00AA, 4'b0000, 0, "t3_drop1");
    sof(0);
    px(0, 16'h00BB, 4'b0000, 0, "t3_drop2");
    check("t3_dropped", 32'(a_drop), 32'd2);
    check("t3_done2", 32'(a_done), 32'd2);

    // T5: release buffer 1, then a short frame
    a_dfs = 1'b1;
    tick();
    a_dfs = 1'b0;
    check("t5_disp", 32'(a_disp_buf), 32'd0);
    tick();
    sof(0);
    for (int k = 1; k <= 5; k++) px(0, 16'(16'h20 + k), 4'b0010, k - 1, "t5_px");
    sof(0);
    check("t5_short", 32'(a_short), 32'd1);
    px(0, 16'h0031, 4'b0010, 0, "t5_restart");
    px(0, 16'h0032, 4'b0010, 1, "t5_next");
    check("t5_done", 32'(a_done), 32'd2);
    check("t5_sticky", 32'(a_short), 32'd1);

    // T6: reset in the middle of a capture
    a_valid = 1'b1;
    a_data = 16'h0077;
    reset = 1'b1;
    tick();
    a_valid = 1'b0;
    check("t6_wr_en", 32'(a_wr_en), 32'd0);
    check("t6_done",  32'(a_done), 32'd0);
    check("t6_drop",  32'(a_drop), 32'd0);
    check("t6_short", 32'(a_short), 32'd0);
    check("t6_disp",  32'(a_disp_buf), 32'd0);
    check("t6_rdaddr", 32'(a_rd_addr), 32'd0);
    check("t6_pix",   32'(a_pix), 32'd0);
    reset = 1'b0;
    a_x = 11'd0; a_y = 11'd0;
    tick();
    tick();
    tick();
    check("t6_act", 32'(a_act), 32'd0);
    check("t6_pix2", 32'(a_pix), 32'd0);

    // T4: triple buffer rotates 1 -> 2 -> 1 with display stuck on 0
    b_en = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      sof(1);
      for (int k = 1; k <= 8; k++)
        px(1, 16'(f * 8 + k), (f == 1) ? 4'b0100 : 4'b0010, k - 1, "t4_px");
      tick();
      tick();
    end
    check("t4_done", 32'(b_done), 32'd3);
    check("t4_drop", 32'(b_drop), 32'd0);
    check("t4_disp", 32'(b_disp_buf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
